matrix_instr_loader: RTL and testbench
======================================

// Module: matrix_instr_loader
// PURPOSE
//  Upstream front-end of the matrix coprocessor. Accepts 32-bit instructions from the host,
//  assembles 5x5 8-bit matrices A and B in staging registers, writes them to the 256-bit
//  single-port matrix RAM, then launches the add/sub operation and waits for completion.
//  It owns the RAM write port during load; the coprocessor owns it while op_start is high.
// PARAMETERS
//  ADDR_A    8'd1   RAM word address for matrix A
//  ADDR_B    8'd2   RAM word address for matrix B
//  N_ELEM    25     valid elements per matrix (index 0..24); bytes 25..31 are padding, always 0
// PORTS
//  clk        in   1    system clock, all logic on posedge
//  rst_n      in   1    asynchronous active-low reset
//  instr      in   32   instruction word
//  instr_valid in  1    host has an instruction on instr
//  instr_ready out 1    loader can accept; transfer when instr_valid && instr_ready
//  ram_addr   out  8    RAM address
//  ram_wdata  out  256  RAM write data (staging buffer selected by COMMIT)
//  ram_wren   out  1    RAM write enable, one-cycle pulse
//  op_code    out  2    operation to coprocessor: bit0 1=sub 0=add; bit1 always 0 (no reset op)
//  op_start   out  1    level, high from EXEC launch until op_done
//  op_done    in   1    coprocessor finished (result written)
//  busy       out  1    high whenever state != IDLE
//  error      out  1    sticky illegal-instruction flag
// BEHAVIOUR
//  Instruction: [31:28] opcode, [27] matrix sel (0=A,1=B), [24:20] element idx, [7:0] data/op.
//  Opcodes: 0 NOP; 1 LOAD; 2 COMMIT; 3 EXEC; 4 CLEAR; 5..15 illegal.
//  Reset: all outputs 0 except instr_ready=1; staging buffers A,B=0; state IDLE; error=0.
//  FSM: IDLE -> WRITE (COMMIT) -> IDLE; IDLE -> EXEC_WAIT (EXEC) -> IDLE. instr_ready=1 only in IDLE.
//  NOP: consumed, no effect.
//  LOAD: buffer[sel][idx*8 +: 8] <= data at accept edge; stays IDLE, back-to-back LOADs every cycle.
//   idx >= N_ELEM: no write, error<=1.
//  COMMIT: accept at edge N; cycle N..N+1: ram_addr=sel?ADDR_B:ADDR_A, ram_wdata=buffer[sel],
//   ram_wren=1 for exactly one cycle, instr_ready=0; IDLE again after edge N+1.
//   ram_wdata/ram_addr hold last values when ram_wren=0.
//  EXEC: op_code<=data[0] latched at accept; op_start=1 from next cycle until op_done sampled
//   high; op_start falls on that edge, op_code held; return to IDLE. op_done outside
//   EXEC_WAIT is ignored. No timeout.
//  CLEAR: both buffers <= 0, error <= 0; stays IDLE.
//  Illegal opcode: consumed, error<=1, no other effect.
//  Same-cycle LOAD to buffer being committed cannot occur (ready=0 in WRITE).
//  rst_n low mid-WRITE or mid-EXEC: immediate return to reset values; ram_wren and op_start
//   drop asynchronously; partially loaded buffers are lost.
// STRUCTURE
//  matrix_pkg: opcode constants (OP_NOP..OP_CLEAR), ELEM_W=8, N_ELEM, ADDR_A/B/C, state enum.
//  Sub-module matrix_stage_buffer: 256-bit register, byte-lane write by idx, sync clear,
//   async reset; instantiated twice (A, B). FSM and decode stay in top.
// TESTING
//  1 Reset: rst_n=0 -> instr_ready=1, ram_wren=0, op_start=0, error=0, busy=0.
//  2 LOAD A idx0=0x05, idx24=0x11; COMMIT A -> one ram_wren pulse, ram_addr=1,
//    wdata[7:0]=05, wdata[199:192]=11, others 0; instr_ready low exactly one cycle.
//  3 LOAD B idx3=0x7F; COMMIT B -> ram_addr=2, wdata[31:24]=7F; A buffer unchanged.
//  4 EXEC data=1 -> op_code=01, op_start high; hold op_done=0 10 cycles (instr ignored,
//    ready=0); op_done=1 -> op_start low next edge, ready=1.
//  5 LOAD idx=25 and opcode 9 -> error=1, buffers unchanged; CLEAR -> error=0, buffers 0.
//  6 Assert rst_n=0 during EXEC_WAIT -> op_start=0 immediately; after release IDLE, buffers 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, instruction layout and FSM states for the matrix coprocessor loader.
// No latency or backpressure of its own; it only provides types to the loader modules.
package matrix_pkg;

  localparam int ELEM_W = 8;
  localparam int N_ELEM = 25;
  localparam int BUF_W  = 256;

  localparam logic [7:0] ADDR_A = 8'd1;
  localparam logic [7:0] ADDR_B = 8'd2;
  localparam logic [7:0] ADDR_C = 8'd3;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_COMMIT = 4'd2;
  localparam logic [3:0] OP_EXEC   = 4'd3;
  localparam logic [3:0] OP_CLEAR  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_EXEC_WAIT
  } state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic        sel;
    logic [1:0]  rsvd_hi;
    logic [4:0]  idx;
    logic [11:0] rsvd_lo;
    logic [7:0]  data;
  } instr_t;

  // Bytes at N_ELEM and above are padding and must stay zero.
  function automatic logic idx_ok(input logic [4:0] idx);
    return idx < 5'(N_ELEM);
  endfunction

endpackage

// File: rtl/matrix_stage_buffer.sv
// 256-bit matrix staging register with byte-lane writes; one-cycle write latency.
// No backpressure: a write or clear is applied on the edge it is presented.
module matrix_stage_buffer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [4:0]        idx,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic              clear,
  output logic [BUF_W-1:0]  data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (wr_en && idx_ok(idx)) begin
      data[{idx, 3'b000} +: ELEM_W] <= wr_data;
    end
  end

endmodule

// File: rtl/matrix_instr_loader.sv
// Host instruction front-end: stages matrices A/B, writes them to RAM, launches add/sub.
// LOAD/NOP/CLEAR take one cycle; COMMIT stalls one cycle; EXEC stalls instr_ready until op_done.
module matrix_instr_loader
  import matrix_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [7:0]   ram_addr,
  output logic [255:0] ram_wdata,
  output logic         ram_wren,
  output logic [1:0]   op_code,
  output logic         op_start,
  input  logic         op_done,
  output logic         busy,
  output logic         error
);

  instr_t             ins;
  state_t             state, state_nxt;
  logic               load_a, load_b, clr, commit, exec, set_err;
  logic [BUF_W-1:0]   buf_a, buf_b;
  logic               unused_bits;

  assign ins         = instr_t'(instr);
  assign unused_bits = ^{ins.rsvd_hi, ins.rsvd_lo, ins.data[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    clr         = 1'b0;
    commit      = 1'b0;
    exec        = 1'b0;
    set_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (ins.opcode)
            OP_NOP: ;
            OP_LOAD: begin
              if (!idx_ok(ins.idx)) set_err = 1'b1;
              else if (ins.sel)     load_b  = 1'b1;
              else                  load_a  = 1'b1;
            end
            OP_COMMIT: begin
              commit    = 1'b1;
              state_nxt = ST_WRITE;
            end
            OP_EXEC: begin
              exec      = 1'b1;
              state_nxt = ST_EXEC_WAIT;
            end
            OP_CLEAR: clr = 1'b1;
            default:  set_err = 1'b1;
          endcase
        end
      end
      ST_WRITE:     state_nxt = ST_IDLE;
      ST_EXEC_WAIT: if (op_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from the state register so both strobes drop the moment reset asserts.
  assign ram_wren = (state == ST_WRITE);
  assign op_start = (state == ST_EXEC_WAIT);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      op_code   <= '0;
      error     <= 1'b0;
    end else begin
      if (commit) begin
        ram_addr  <= ins.sel ? ADDR_B : ADDR_A;
        ram_wdata <= ins.sel ? buf_b : buf_a;
      end
      if (exec)         op_code <= {1'b0, ins.data[0]};
      if (clr)          error   <= 1'b0;
      else if (set_err) error   <= 1'b1;
    end
  end

  matrix_stage_buffer u_buf_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_a),
    .idx     (ins.idx),
    .wr_data (ins.data),
    .clear   (clr),
    .data    (buf_a)
  );

  matrix_stage_buffer u_buf_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_b),
    .idx     (ins.idx),
    .wr_data (ins.data),
    .clear   (clr),
    .data    (buf_b)
  );

endmodule

// File: tb/tb_matrix_instr_loader.sv
// Scoreboard bench for matrix_instr_loader: expected RAM writes are queued at COMMIT
// and compared by a negedge monitor; scenario tasks check control outputs inline.
module tb_matrix_instr_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  instr = '0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [7:0]   ram_addr;
  logic [255:0] ram_wdata;
  logic         ram_wren;
  logic [1:0]   op_code;
  logic         op_start;
  logic         op_done = 1'b0;
  logic         busy;
  logic         error;

  int errors = 0;
  int checks = 0;
  int wren_cnt = 0;

  typedef struct packed {
    logic [7:0]   addr;
    logic [255:0] data;
  } wr_t;

  wr_t          exp_q[$];
  logic [255:0] m_a = '0;
  logic [255:0] m_b = '0;

  matrix_instr_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wren    (ram_wren),
    .op_code     (op_code),
    .op_start    (op_start),
    .op_done     (op_done),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ram_wren) begin
      wr_t e;
      wren_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected addr=%0d data=%h", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data) begin
          errors++;
          $display("FAIL ram_write got addr=%0d data=%h exp addr=%0d data=%h",
                   ram_addr, ram_wdata, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] op, input logic sel,
                                     input logic [4:0] idx, input logic [7:0] d);
    return {op, sel, 2'b00, idx, 12'h000, d};
  endfunction

  // Drives one instruction and returns #1 after the edge that accepted it.
  task automatic send(input logic [31:0] w);
    int n = 0;
    instr       = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout instr=%h", w);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic load(input logic sel, input logic [4:0] idx, input logic [7:0] d);
    send(mk(4'd1, sel, idx, d));
    if (idx < 5'd25) begin
      if (sel) m_b[idx*8 +: 8] = d;
      else     m_a[idx*8 +: 8] = d;
    end
  endtask

  task automatic commit(input logic sel);
    wr_t e;
    int  c0;
    e.addr = sel ? 8'd2 : 8'd1;
    e.data = sel ? m_b : m_a;
    exp_q.push_back(e);
    c0 = wren_cnt;
    send(mk(4'd2, sel, 5'd0, 8'd0));
    checks++;
    if (ram_wren !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL commit_write_cycle wren=%b ready=%b busy=%b exp 1 0 1", ram_wren, instr_ready, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (ram_wren !== 1'b0 || instr_ready !== 1'b1 || ram_addr !== e.addr) begin
      errors++;
      $display("FAIL commit_after wren=%b ready=%b addr=%0d exp 0 1 %0d", ram_wren, instr_ready, ram_addr, e.addr);
    end
    @(posedge clk); #1;
    checks++;
    if (wren_cnt - c0 != 1) begin
      errors++;
      $display("FAIL commit_pulse_count got=%0d exp=1", wren_cnt - c0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({instr_ready, ram_wren, op_start, error, busy, op_code, ram_addr} !== {1'b1, 4'b0, 2'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state ready=%b wren=%b start=%b err=%b busy=%b code=%0d addr=%0d exp 1 0 0 0 0 0 0",
               instr_ready, ram_wren, op_start, error, busy, op_code, ram_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_commit_a();
    load(1'b0, 5'd0, 8'h05);
    load(1'b0, 5'd24, 8'h11);
    commit(1'b0);
  endtask

  task automatic test_commit_b();
    load(1'b1, 5'd3, 8'h7F);
    commit(1'b1);
    commit(1'b0);
  endtask

  task automatic test_exec();
    send(mk(4'd3, 1'b0, 5'd0, 8'h01));
    checks++;
    if (op_start !== 1'b1 || op_code !== 2'b01 || instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL exec_launch start=%b code=%0d ready=%b exp 1 1 0", op_start, op_code, instr_ready);
    end
    instr = mk(4'd1, 1'b0, 5'd1, 8'hAA);
    instr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (op_start !== 1'b1 || instr_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL exec_wait cyc=%0d start=%b ready=%b busy=%b exp 1 0 1", i, op_start, instr_ready, busy);
      end
    end
    instr_valid = 1'b0;
    op_done = 1'b1;
    @(posedge clk); #1;
    op_done = 1'b0;
    checks++;
    if (op_start !== 1'b0 || instr_ready !== 1'b1 || op_code !== 2'b01) begin
      errors++;
      $display("FAIL exec_done start=%b ready=%b code=%0d exp 0 1 1", op_start, instr_ready, op_code);
    end
    op_done = 1'b1;
    @(posedge clk); #1;
    op_done = 1'b0;
    checks++;
    if (op_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_op_done start=%b busy=%b exp 0 0", op_start, busy);
    end
    commit(1'b0);
    send(mk(4'd3, 1'b0, 5'd0, 8'hFE));
    op_done = 1'b1;
    @(posedge clk); #1;
    op_done = 1'b0;
    checks++;
    if (op_code !== 2'b00 || op_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL exec_add code=%0d start=%b busy=%b exp 0 0 0", op_code, op_start, busy);
    end
  endtask

  task automatic test_errors();
    load(1'b0, 5'd25, 8'h33);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL err_bad_idx got=%b exp=1", error); end
    send(mk(4'd4, 1'b0, 5'd0, 8'd0));
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", error); end
    m_a = '0; m_b = '0;
    load(1'b1, 5'd24, 8'h9C);
    send(mk(4'd0, 1'b1, 5'd24, 8'h55));
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nop err=%b busy=%b exp 0 0", error, busy);
    end
    send(mk(4'd9, 1'b1, 5'd24, 8'h66));
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL err_illegal got=%b exp=1", error); end
    load(1'b1, 5'd31, 8'h77);
    commit(1'b1);
    commit(1'b0);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", error); end
    send(mk(4'd4, 1'b0, 5'd0, 8'd0));
    m_a = '0; m_b = '0;
    commit(1'b1);
  endtask

  task automatic test_reset_exec();
    load(1'b0, 5'd5, 8'h42);
    send(mk(4'd3, 1'b0, 5'd0, 8'h01));
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (op_start !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1 || op_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_in_exec start=%b busy=%b ready=%b code=%0d exp 0 0 1 0", op_start, busy, instr_ready, op_code);
    end
    m_a = '0; m_b = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    commit(1'b0);
  endtask

  initial begin
    test_reset();
    test_commit_a();
    test_commit_b();
    test_exec();
    test_errors();
    test_reset_exec();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
